fp16_mult_sched: RTL and testbench
==================================

// Module: fp16_mult_sched
// PURPOSE
//  Shares one pipelined fp16 multiplier among N Kalman-update requesters (predict, gain, covariance).
//  Round-robin arbitration with valid/ready on the request side. Operands go to the external multiplier.
//  A tag pipeline tracks each in-flight product and routes it back to its originator as a one-hot response.
//  No response backpressure: requesters must sink rsp_valid in the cycle it is asserted.
// PARAMETERS
//  N_REQ    3   number of requesters, 2..8
//  MUL_LAT  4   cycles from mul_a/mul_b presented to mul_result valid; fixed, >=1
//  ID_W     2   requester id width, $clog2(N_REQ)
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          asynchronous, active-high reset
//  req_valid   in   N_REQ      request i has operands on req_a/req_b slice i
//  req_ready   out  N_REQ      one-hot grant; transfer on req_valid[i] & req_ready[i]
//  req_a       in   16*N_REQ   fp16 operand A, slice i = [16*i+15:16*i]
//  req_b       in   16*N_REQ   fp16 operand B
//  flush       in   1          synchronous: discard all in-flight products
//  mul_a       out  16         operand A to multiplier, registered
//  mul_b       out  16         operand B to multiplier, registered
//  mul_result  in   16         multiplier product
//  rsp_valid   out  N_REQ      one-hot, product for requester i valid this cycle
//  rsp_data    out  16         product, registered
//  busy        out  1          any tag-pipe stage valid, or mul operands valid
// BEHAVIOUR
//  Reset:
//  - req_ready, rsp_valid and busy go 0.
//  - mul_a, mul_b and rsp_data go 16'h0000.
//  - rr pointer goes to 0 and all tag-pipe valids go 0.
//  Arbitration (combinational req_ready):
//  - Grant the first i with req_valid[i], scanning ptr, ptr+1, ... mod N_REQ.
//  - req_ready is zero when no req_valid, or when flush is high.
//  - Pointer update: on a transfer to i, ptr <= (i+1) mod N_REQ; otherwise it holds.
//  - At most one transfer per cycle, so throughput is 1 product/cycle.
//  Issue:
//  - Transfer in cycle c: mul_a/mul_b <= granted operands, valid during c+1.
//  - Idle cycle: mul_a/mul_b <= 0.
//  - A stage-0 tag {v=1, id=i} enters the tag pipe with the operands.
//  Tag pipe:
//  - MUL_LAT+1 stages of {v, id}, shifting every cycle (no stalls).
//  - The tail tag aligns with mul_result in cycle c+1+MUL_LAT.
//  Response (registered, cycle c+2+MUL_LAT):
//  - rsp_valid <= tail.v ? (1<<tail.id) : 0.
//  - rsp_data <= tail.v ? mul_result : rsp_data (holds otherwise).
//  - Total request-to-response latency is MUL_LAT+2 cycles.
//  Ordering: responses return in issue order; per-requester order is preserved.
//  Flush:
//  - In its cycle, flush clears every tag-pipe v bit and the response register valid.
//  - No grant is made in that cycle.
//  - Products of earlier transfers are never reported.
//  - Transfers from the following cycle onward proceed normally.
//  Reset mid-operation: all in-flight products are lost and nothing is reported afterwards.
//  Simultaneous events:
//  - All N_REQ valid: strict rotation 0,1,2,0,...
//  - Requester i may re-request in the cycle after its grant but waits its turn.
//  - Response for i coincides with a new grant to i: both happen, they are independent.
//  Arithmetic: no fp arithmetic here; operands pass through bit-exact.
//  Unused requester ids (id >= N_REQ) never appear.
// STRUCTURE
//  Shared package kalman_pkg:
//  - fp16_t (logic [15:0]).
//  - FP16_ZERO = 16'h0000, FP16_ONE = 16'h3C00.
//  - Default MUL_LAT constant, shared with the multiplier's stage count.
//  One sub-module: rr_arbiter.
//  - Parameter N.
//  - Inputs req, advance. Outputs one-hot grant and internal pointer.
//  - Reused later for the adder scheduler.
//  The tag pipe and response register stay inline.
// TESTING (N_REQ=3, MUL_LAT=4; behavioural multiplier model with 4-cycle delay)
//  1. Single request, cycle 10: req 1, a=0x4000 (2.0), b=0x4200 (3.0).
//     -> req_ready=3'b010 in cycle 10; mul_a=0x4000 in cycle 11.
//     -> rsp_valid=3'b010 and rsp_data=0x4600 in cycle 16; busy high cycles 11..15.
//  2. All three valid for 6 cycles -> grants 0,1,2,0,1,2 in consecutive cycles.
//     -> responses in the same order, back-to-back, each 6 cycles after its grant.
//  3. Fairness: req 0 held valid continuously, req 2 asserted once.
//     -> req 2 is granted within 2 cycles, and req 0 is never granted twice in a row while req 2 waits.
//  4. Flush: issue 3 products (cycles 0..2), flush in cycle 4.
//     -> no rsp_valid for any of them and req_ready=0 in cycle 4.
//     -> request in cycle 5 of 0x3E00*0x3E00 returns 0x4080 (2.25) in cycle 11.
//  5. Reset asserted asynchronously mid-flight (cycle 3 of 6 products).
//     -> all outputs 0 immediately; no rsp_valid after deassertion; ptr restarts at 0.
//  6. Idle: no req_valid for 20 cycles -> mul_a=mul_b=0, rsp_valid=0, busy=0 throughout.

Source files
------------

// File: rtl/kalman_pkg.sv
// Shared fp16 types and constants for the Kalman-update datapath schedulers.
// The default multiplier latency here also sizes the external multiplier's pipeline.
package kalman_pkg;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_ZERO       = 16'h0000;
    localparam fp16_t FP16_ONE        = 16'h3C00;
    localparam int    MUL_LAT_DEFAULT = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning from ptr upward, mod N.
// Pointer moves to one past the granted requester only when the grant is taken (advance).
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] grant_idx;
    logic          found;

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

endmodule

// File: rtl/fp16_mult_sched.sv
// Shares one pipelined fp16 multiplier among N_REQ requesters; request-to-response is MUL_LAT+2 cycles.
// Requests are flow-controlled by a one-hot round-robin ready; responses cannot be backpressured.
module fp16_mult_sched
    import kalman_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    input  logic                 flush,
    output fp16_t                mul_a,
    output fp16_t                mul_b,
    input  fp16_t                mul_result,
    output logic [N_REQ-1:0]     rsp_valid,
    output fp16_t                rsp_data,
    output logic                 busy
);

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  rr_ptr;
    logic             xfer;
    logic [ID_W-1:0]  xfer_id;
    fp16_t            sel_a;
    fp16_t            sel_b;
    logic [MUL_LAT:0] tag_v;
    logic [ID_W-1:0]  tag_id [MUL_LAT+1];
    logic             tail_live;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (xfer),
        .grant   (grant),
        .ptr     (rr_ptr)
    );

    // Flush cycles accept nothing, so no new product can slip past the clear.
    assign req_ready = (reset || flush) ? '0 : grant;
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        sel_a   = FP16_ZERO;
        sel_b   = FP16_ZERO;
        xfer_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sel_a   = req_a[16*i +: 16];
                sel_b   = req_b[16*i +: 16];
                xfer_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a <= FP16_ZERO;
            mul_b <= FP16_ZERO;
        end else begin
            mul_a <= sel_a;
            mul_b <= sel_b;
        end
    end

    // Tag pipe runs alongside the multiplier; stage MUL_LAT lines up with mul_result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            for (int s = 0; s <= MUL_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_v     <= flush ? '0 : {tag_v[MUL_LAT-1:0], xfer};
            tag_id[0] <= xfer_id;
            for (int s = 1; s <= MUL_LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    assign tail_live = tag_v[MUL_LAT] && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= FP16_ZERO;
        end else begin
            rsp_valid <= tail_live ? (N_REQ'(1) << tag_id[MUL_LAT]) : '0;
            if (tail_live) begin
                rsp_data <= mul_result;
            end
        end
    end

    // Stage 0 valid is exactly "mul operands valid", so the tag bits cover both.
    assign busy = |tag_v;

    grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    ptr_in_range: assert property (@(posedge clk) disable iff (reset) int'(rr_ptr) < N_REQ);

endmodule

// File: tb/tb_fp16_mult_sched.sv
// Bench for fp16_mult_sched: directed scenarios plus randomized traffic against a queue-based model.
module tb_fp16_mult_sched;

    localparam int N       = 3;
    localparam int LAT     = 4;
    localparam int RSP_LAT = LAT + 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic            flush;
    logic [15:0]     mul_a;
    logic [15:0]     mul_b;
    logic [15:0]     mul_result;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_data;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    fp16_mult_sched #(.N_REQ(N), .MUL_LAT(LAT), .ID_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Truncating fp16 multiply for normal operands; zero exponent treated as zero.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        int         ea;
        int         eb;
        int         e;
        longint     p;
        logic [9:0] m;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if (ea == 0 || eb == 0) return 16'h0000;
        p = longint'({1'b1, a[9:0]}) * longint'({1'b1, b[9:0]});
        e = ea + eb - 15;
        if (p >= 64'd2097152) begin
            e = e + 1;
            m = 10'(p >> 11);
        end else begin
            m = 10'(p >> 10);
        end
        return {a[15] ^ b[15], 5'(e), m};
    endfunction

    function automatic logic [15:0] rand_fp16();
        return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
    endfunction

    // External multiplier model: product of the operands presented LAT cycles earlier.
    logic [15:0] pa [LAT];
    logic [15:0] pb [LAT];
    initial begin
        for (int s = 0; s < LAT; s++) begin
            pa[s] = 16'h0000;
            pb[s] = 16'h0000;
        end
    end
    always @(posedge clk) begin
        pa[0] <= mul_a;
        pb[0] <= mul_b;
        for (int s = 1; s < LAT; s++) begin
            pa[s] <= pa[s-1];
            pb[s] <= pb[s-1];
        end
    end
    assign mul_result = fp16_mul(pa[LAT-1], pb[LAT-1]);

    // Reference model: expected responses queued in issue order with their due cycle.
    typedef struct {
        int          due;
        int          id;
        logic [15:0] data;
    } exp_t;

    exp_t m_q[$];
    int   m_ptr = 0;

    function automatic int model_grant(input logic [N-1:0] v, input logic fl, input logic rs, input int ptr);
        if (fl || rs) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_ptr = 0;
        end else begin
            int g;
            g = model_grant(req_valid, flush, 1'b0, m_ptr);
            if (m_q.size() > 0 && m_q[0].due == cyc) void'(m_q.pop_front());
            if (flush) m_q.delete();
            if (g >= 0) begin
                m_q.push_back('{cyc + RSP_LAT, g, fp16_mul(req_a[16*g +: 16], req_b[16*g +: 16])});
                m_ptr = (g + 1) % N;
            end
        end
    end

    function automatic logic [N-1:0] model_rsp_valid();
        if (m_q.size() > 0 && m_q[0].due == cyc) return N'(1) << m_q[0].id;
        return '0;
    endfunction

    function automatic logic model_busy();
        foreach (m_q[i]) if (m_q[i].due > cyc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        flush     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = rand_fp16();
            req_b[16*i +: 16] = rand_fp16();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        flush     = 1'b0;
        rand_operands();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        n_cmp++; if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 000", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (mul_a !== 16'h0000 || mul_b !== 16'h0000) begin n_err++; $display("FAIL reset_mul: got %h/%h want 0000/0000", mul_a, mul_b); end
        n_cmp++; if (rsp_data !== 16'h0000) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
        tick();
        reset     = 1'b0;
        req_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_single();
        logic exp_busy;
        req_a = '0;
        req_b = '0;
        req_a[31:16] = 16'h4000;
        req_b[31:16] = 16'h4200;
        req_valid = 3'b010;
        @(negedge clk);
        n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL single_ready: got %b want 010", req_ready); end
        tick();
        req_valid = '0;
        for (int k = 1; k <= RSP_LAT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++; if (mul_a !== 16'h4000 || mul_b !== 16'h4200) begin n_err++; $display("FAIL single_mul_ops: got %h/%h want 4000/4200", mul_a, mul_b); end
            end
            exp_busy = (k <= LAT + 1);
            n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL single_busy k=%0d: got %b want %b", k, busy, exp_busy); end
            if (k == RSP_LAT) begin
                n_cmp++; if (rsp_valid !== 3'b010) begin n_err++; $display("FAIL single_rsp_valid: got %b want 010", rsp_valid); end
                n_cmp++; if (rsp_data !== 16'h4600) begin n_err++; $display("FAIL single_rsp_data: got %h want 4600", rsp_data); end
            end else begin
                n_cmp++; if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL single_rsp_early k=%0d: got %b want 000", k, rsp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [15:0]  exp_d [6];
        logic [N-1:0] exp_g;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            rand_operands();
            req_valid = '1;
            exp_g     = N'(1) << (k % N);
            exp_d[k]  = fp16_mul(req_a[16*(k%N) +: 16], req_b[16*(k%N) +: 16]);
            @(negedge clk);
            n_cmp++; if (req_ready !== exp_g) begin n_err++; $display("FAIL rr_grant k=%0d: got %b want %b", k, req_ready, exp_g); end
            tick();
        end
        req_valid = '0;
        for (int j = 0; j < 6; j++) begin
            exp_g = N'(1) << (j % N);
            @(negedge clk);
            n_cmp++; if (rsp_valid !== exp_g) begin n_err++; $display("FAIL rr_rsp_valid j=%0d: got %b want %b", j, rsp_valid, exp_g); end
            n_cmp++; if (rsp_data !== exp_d[j]) begin n_err++; $display("FAIL rr_rsp_data j=%0d: got %h want %h", j, rsp_data, exp_d[j]); end
            tick();
        end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL rr_rsp_after: got %b want 000", rsp_valid); end
        tick();
    endtask

    task automatic test_fairness();
        int   waited;
        logic granted2;
        logic prev0;
        apply_reset();
        rand_operands();
        waited    = 0;
        granted2  = 1'b0;
        prev0     = 1'b0;
        req_valid = 3'b001;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) req_valid[2] = 1'b1;
            @(negedge clk);
            if (req_valid[2] && !granted2) begin
                waited++;
                n_cmp++; if (req_ready[0] && prev0) begin n_err++; $display("FAIL fair_req0_twice k=%0d: got ready %b want req0 skipped", k, req_ready); end
                if (req_ready[2]) begin
                    granted2 = 1'b1;
                    n_cmp++; if (waited > 2) begin n_err++; $display("FAIL fair_wait: got %0d cycles want <=2", waited); end
                end
            end
            prev0 = req_ready[0];
            tick();
            if (granted2) req_valid[2] = 1'b0;
        end
        req_valid = '0;
        n_cmp++; if (granted2 !== 1'b1) begin n_err++; $display("FAIL fair_granted: got %b want 1", granted2); end
    endtask

    task automatic test_flush();
        logic [N-1:0] exp_v;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            rand_operands();
            req_valid = N'(1) << k;
            tick();
        end
        req_valid = '0;
        tick();
        flush     = 1'b1;
        req_valid = '1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL flush_ready: got %b want 000", req_ready); end
        tick();
        flush     = 1'b0;
        req_valid = 3'b010;
        req_a[31:16] = 16'h3E00;
        req_b[31:16] = 16'h3E00;
        @(negedge clk);
        n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL flush_next_ready: got %b want 010", req_ready); end
        tick();
        req_valid = '0;
        for (int c = 6; c <= 12; c++) begin
            exp_v = (c == 11) ? 3'b010 : 3'b000;
            @(negedge clk);
            n_cmp++; if (rsp_valid !== exp_v) begin n_err++; $display("FAIL flush_rsp_valid c=%0d: got %b want %b", c, rsp_valid, exp_v); end
            if (c == 11) begin
                n_cmp++; if (rsp_data !== 16'h4080) begin n_err++; $display("FAIL flush_rsp_data: got %h want 4080", rsp_data); end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            rand_operands();
            req_valid = '1;
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL areset_ready: got %b want 000", req_ready); end
        n_cmp++; if (mul_a !== 16'h0000 || mul_b !== 16'h0000) begin n_err++; $display("FAIL areset_mul: got %h/%h want 0000/0000", mul_a, mul_b); end
        n_cmp++; if (rsp_valid !== 3'b000 || rsp_data !== 16'h0000) begin n_err++; $display("FAIL areset_rsp: got %b/%h want 000/0000", rsp_valid, rsp_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b want 0", busy); end
        tick();
        reset     = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL areset_quiet k=%0d: got rsp %b busy %b want 000 0", k, rsp_valid, busy); end
            tick();
        end
        req_valid = '1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL areset_ptr: got %b want 001", req_ready); end
        tick();
        req_valid = '0;
    endtask

    task automatic test_idle();
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            rand_operands();
            @(negedge clk);
            n_cmp++;
            if (mul_a !== 16'h0000 || mul_b !== 16'h0000 || rsp_valid !== 3'b000 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle k=%0d: got mul %h/%h rsp %b busy %b want 0000/0000 000 0", k, mul_a, mul_b, rsp_valid, busy);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int           g;
        logic [N-1:0] exp_r;
        logic [N-1:0] exp_v;
        logic         exp_b;
        apply_reset();
        for (int k = 0; k < 320; k++) begin
            if (k < 300) begin
                rand_operands();
                req_valid = N'($urandom);
                flush     = ($urandom_range(0, 19) == 0);
            end else begin
                req_valid = '0;
                flush     = 1'b0;
            end
            @(negedge clk);
            g     = model_grant(req_valid, flush, reset, m_ptr);
            exp_r = (g >= 0) ? (N'(1) << g) : '0;
            exp_v = model_rsp_valid();
            exp_b = model_busy();
            n_cmp++; if (req_ready !== exp_r) begin n_err++; $display("FAIL b2b_ready k=%0d: got %b want %b", k, req_ready, exp_r); end
            n_cmp++; if (rsp_valid !== exp_v) begin n_err++; $display("FAIL b2b_rsp_valid k=%0d: got %b want %b", k, rsp_valid, exp_v); end
            if (exp_v != '0) begin
                n_cmp++; if (rsp_data !== m_q[0].data) begin n_err++; $display("FAIL b2b_rsp_data k=%0d: got %h want %h", k, rsp_data, m_q[0].data); end
            end
            n_cmp++; if (busy !== exp_b) begin n_err++; $display("FAIL b2b_busy k=%0d: got %b want %b", k, busy, exp_b); end
            tick();
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        flush     = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_flush();
        test_async_reset();
        test_idle();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
